ccg_sweep_ctrl: RTL and testbench

Exhaustive-sweep controller for the small combinational benchmark circuits (CUTs) in the dataset flow, for example 3-input/8-output CCG netlists. On `start` it drives the CUT through all 2^N_IN input vectors and waits a programmable settle time after each one. It then writes each captured output vector to a truth-table sink, compacts the outputs into a MISR signature, and flags outputs that stayed constant over the sweep (such as tied-to-1 outputs).

---
 rtl/ccg_sweep_pkg.sv | 14 +
 rtl/ccg_misr.sv | 36 +++
 rtl/ccg_sweep_ctrl.sv | 135 +++++++++++++
 tb/tb_ccg_sweep_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ccg_sweep_pkg.sv
// Shared types and constants for the exhaustive-sweep controller and its MISR.
package ccg_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

endpackage

// File: rtl/ccg_misr.sv
// Multiple-input signature register: shift with CCITT-style feedback, then fold in the
// zero-extended data word.
module ccg_misr
  import ccg_sweep_pkg::*;
#(
  parameter int              SIG_W = 16,
  parameter int              N_OUT = 8,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             en,
  input  logic [N_OUT-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sh;

  always_comb begin
    sh = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0);
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '1;
    end else if (init) begin
      sig <= '1;
    end else if (en) begin
      sig <= sh ^ SIG_W'(din);
    end
  end

endmodule

// File: rtl/ccg_sweep_ctrl.sv
// Drives a combinational CUT through every input vector, writes a truth table, builds a
// MISR signature and tracks which outputs stayed constant for the whole sweep.
module ccg_sweep_ctrl
  import ccg_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 8,
  parameter int SETTLE = 2,
  parameter int SIG_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic             tt_wr_en,
  output logic [N_IN-1:0]  tt_addr,
  output logic [N_OUT-1:0] tt_data,
  output logic [SIG_W-1:0] signature,
  output logic [N_OUT-1:0] const_mask,
  output logic [N_OUT-1:0] const_val
);

  localparam int              VEC_W = N_IN + 1;
  localparam int              CNT_W = $clog2(SETTLE + 1);
  localparam logic [VEC_W-1:0] LAST = VEC_W'((1 << N_IN) - 1);

  state_t           state, state_next;
  logic [VEC_W-1:0] vec;
  logic [CNT_W-1:0] cnt;
  logic             accept, cap_fire, finish;

  // NOTE: every signal assigned in this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    cap_fire   = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next = ST_SETTLE;
          accept     = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort)                   state_next = ST_IDLE;
        else if (cnt == CNT_W'(1))   state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else begin
          cap_fire   = 1'b1;
          state_next = (vec == LAST) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        finish     = !abort;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec          <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      tt_wr_en     <= 1'b0;
      tt_addr      <= '0;
      tt_data      <= '0;
      const_mask   <= '1;
      const_val    <= '0;
    end else begin
      done     <= finish;
      tt_wr_en <= cap_fire;
      busy     <= (state_next == ST_SETTLE) || (state_next == ST_CAPTURE);

      if (state == ST_SETTLE) cnt <= cnt - CNT_W'(1);

      if (accept) begin
        vec          <= '0;
        cnt          <= CNT_W'(SETTLE);
        const_mask   <= '1;
        result_valid <= 1'b0;
      end

      if (cap_fire) begin
        tt_addr <= vec[N_IN-1:0];
        tt_data <= cut_out;
        if (vec == '0) const_val  <= cut_out;
        else           const_mask <= const_mask & ~(cut_out ^ const_val);
        if (vec != LAST) begin
          vec <= vec + VEC_W'(1);
          cnt <= CNT_W'(SETTLE);
        end
      end

      if (finish) result_valid <= 1'b1;

      // Park the CUT at vector 0 whenever the sweep ends, normally or by abort.
      if (state != ST_IDLE && state_next == ST_IDLE) vec <= '0;
    end
  end

  assign cut_in = vec[N_IN-1:0];

  ccg_misr #(
    .SIG_W(SIG_W),
    .N_OUT(N_OUT),
    .POLY (SIG_W'(MISR_POLY))
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .init (accept),
    .en   (cap_fire),
    .din  (cut_out),
    .sig  (signature)
  );

endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// Self-checking bench for ccg_sweep_ctrl: table-driven full sweeps with a write
// scoreboard, plus hand sequences for abort, reset and a reduced configuration.
module tb_ccg_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  cut_in;
  logic [7:0]  cut_out;
  logic        busy, done, result_valid, tt_wr_en;
  logic [2:0]  tt_addr;
  logic [7:0]  tt_data;
  logic [15:0] signature;
  logic [7:0]  const_mask, const_val;

  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic [1:0]  cut_in2;
  logic [7:0]  cut_out2;
  logic        busy2, done2, rv2, wr2;
  logic [1:0]  addr2;
  logic [7:0]  data2;
  logic [15:0] sig2;
  logic [7:0]  mask2, val2;

  int mode = 0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         edge_no;
  } wr_exp_t;
  wr_exp_t exp_q[$];

  typedef struct {
    int         mode;
    logic [7:0] mask;
    logic [7:0] val;
    bit         repulse;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ccg_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cut_in(cut_in), .cut_out(cut_out), .busy(busy), .done(done),
    .result_valid(result_valid), .tt_wr_en(tt_wr_en), .tt_addr(tt_addr),
    .tt_data(tt_data), .signature(signature), .const_mask(const_mask),
    .const_val(const_val)
  );

  ccg_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .cut_in(cut_in2), .cut_out(cut_out2), .busy(busy2), .done(done2),
    .result_valid(rv2), .tt_wr_en(wr2), .tt_addr(addr2),
    .tt_data(data2), .signature(sig2), .const_mask(mask2),
    .const_val(val2)
  );

  function automatic logic [7:0] cut_fn(input int m, input logic [2:0] v);
    case (m)
      0:       return {5'b0, v};
      1:       return {1'b1, v[1] ^ v[2], ~v[0], v[2], 1'b1, 1'b1, v[1], v[0]};
      default: return 8'h5A;
    endcase
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
    logic fb;
    fb = s[15];
    s  = s << 1;
    if (fb) s = s ^ 16'h1021;
    return s ^ {8'h00, d};
  endfunction

  always_comb cut_out  = cut_fn(mode, cut_in);
  always_comb cut_out2 = {6'b0, cut_in2};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write scoreboard: every strobe must match the next expected write, including timing.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (tt_wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected none (cycle %0d)",
                 tt_addr, tt_data, cyc);
      end else begin
        wr_exp_t e;
        e = exp_q.pop_front();
        check("tt_write {addr,data,edge}", {8'(tt_addr), tt_data, 32'(cyc)},
              {8'(e.addr), e.data, 32'(e.edge_no)});
      end
    end
  end

  task automatic pulse_start(output int s);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_writes(input int s, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back('{addr: 3'(k), data: cut_fn(mode, 3'(k)), edge_no: s + 3 * (k + 1)});
  endtask

  task automatic run_sweep(input vec_t t);
    int s, w0;
    logic [15:0] sig_m;
    mode = t.mode;
    w0 = wr_cnt;
    pulse_start(s);
    push_writes(s, 8);
    for (int i = 0; i < 200; i++) begin
      start = t.repulse && (cyc == s + 5 || cyc == s + 12);
      if (done) break;
      @(negedge clk);
    end
    start = 1'b0;
    sig_m = 16'hFFFF;
    for (int k = 0; k < 8; k++) sig_m = misr_step(sig_m, cut_fn(t.mode, 3'(k)));
    check("done_edge", 64'(cyc), 64'(s + 25));
    check("result_valid", 64'(result_valid), 64'd1);
    check("const_mask", 64'(const_mask), 64'(t.mask));
    check("const_val", 64'(const_val), 64'(t.val));
    check("signature", 64'(signature), 64'(sig_m));
    check("write_count", 64'(wr_cnt - w0), 64'd8);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'({done, busy, result_valid}), 64'b001);
  endtask

  initial begin
    int s, n, d0;
    tbl[0] = '{mode: 0, mask: 8'hF8, val: 8'h00, repulse: 1'b0};
    tbl[1] = '{mode: 1, mask: 8'h8C, val: 8'hAC, repulse: 1'b0};
    tbl[2] = '{mode: 2, mask: 8'hFF, val: 8'h5A, repulse: 1'b0};
    tbl[3] = '{mode: 0, mask: 8'hF8, val: 8'h00, repulse: 1'b1};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {cut_in, busy, done, result_valid, tt_wr_en, tt_addr, tt_data, signature, const_mask, const_val},
          {3'd0, 4'b0000, 3'd0, 8'h00, 16'hFFFF, 8'hFF, 8'h00});
    rst_n = 1'b1;

    // start together with abort in IDLE must not begin a sweep
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (4) @(negedge clk);
    check("start_abort_idle", 64'({busy, tt_wr_en, cut_in}), 64'd0);

    for (int i = 0; i < 4; i++) run_sweep(tbl[i]);

    // abort during the third capture: writes 0 and 1 only, no done, no result
    mode = 0;
    d0 = done_cnt;
    pulse_start(s);
    push_writes(s, 2);
    for (int i = 0; i < 40; i++) begin
      abort = (cyc == s + 8);
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_result_valid", 64'(result_valid), 64'd0);
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    check("abort_idle", 64'({busy, cut_in}), 64'd0);
    run_sweep(tbl[0]);

    // asynchronous reset in the middle of SETTLE for vector 1
    mode = 1;
    pulse_start(s);
    push_writes(s, 1);
    for (int i = 0; i < 20 && cyc < s + 4; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {cut_in, busy, done, result_valid, tt_wr_en, tt_addr, tt_data, signature, const_mask, const_val},
          {3'd0, 4'b0000, 3'd0, 8'h00, 16'hFFFF, 8'hFF, 8'h00});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_idle", 64'({busy, cut_in, result_valid}), 64'd0);
    check("post_reset_queue", 64'(exp_q.size()), 64'd0);
    run_sweep(tbl[1]);

    // reduced configuration: 4 vectors, one settle cycle
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (wr2) begin
        check("small_write {addr,data,edge}", {8'(addr2), data2, 32'(cyc)},
              {8'(n), 8'(n), 32'(s + 2 * (n + 1))});
        n++;
      end
      if (done2) begin
        check("small_done_edge", 64'(cyc), 64'(s + 9));
        break;
      end
      @(negedge clk);
    end
    check("small_write_count", 64'(n), 64'd4);
    begin
      logic [15:0] sm;
      sm = 16'hFFFF;
      for (int k = 0; k < 4; k++) sm = misr_step(sm, 8'(k));
      check("small_results", {rv2, mask2, val2, sig2}, {1'b1, 8'hFC, 8'h00, sm});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
